// File: rtl/regf_wb_arb_if.sv
// regf_wb_arb_if: producer channels, control and port C write bus of the write-back arbiter
interface regf_wb_arb_if #(
    parameter int AWIDTH = 5,
    parameter int DWIDTH = 32
);
    logic              halt;
    logic              flush_pipeline;
    logic              a_valid;
    logic              a_ready;
    logic [AWIDTH-1:0] a_addr;
    logic [DWIDTH-1:0] a_data;
    logic              b_valid;
    logic              b_ready;
    logic [AWIDTH-1:0] b_addr;
    logic [DWIDTH-1:0] b_data;
    logic              wec;
    logic [AWIDTH-1:0] addrc;
    logic [DWIDTH-1:0] datac;
    logic              wb_pending;

    modport master (
        output halt, flush_pipeline, a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        input  a_ready, b_ready, wec, addrc, datac, wb_pending
    );

    modport slave (
        input  halt, flush_pipeline, a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        output a_ready, b_ready, wec, addrc, datac, wb_pending
    );
endinterface

// File: rtl/regf_wb_arb.sv
// regf_wb_arb: two-channel write-back queue with round-robin grant onto register file port C
module regf_wb_arb #(
    parameter int AWIDTH     = 5,
    parameter int DWIDTH     = 32,
    parameter int DEPTH_LOG2 = 2
) (
    input logic          clk,
    input logic          reset_b,
    regf_wb_arb_if.slave bus
);
    localparam int W     = AWIDTH + DWIDTH;
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [1:0]               valid, ready, nonempty, push, pop;
    logic [1:0][W-1:0]        din, head;
    logic [1:0][DEPTH_LOG2:0] count;
    logic                     active, grant_a, grant_b, last_b, wec;
    logic [AWIDTH-1:0]        addrc;
    logic [DWIDTH-1:0]        datac;

    assign valid = {bus.b_valid, bus.a_valid};
    assign din   = {{bus.b_addr, bus.b_data}, {bus.a_addr, bus.a_data}};

    // last_b=1 means B was granted last, so A wins the next tie
    always_comb begin
        active  = !bus.flush_pipeline && !bus.halt;
        grant_a = active && nonempty[0] && (!nonempty[1] || last_b);
        grant_b = active && nonempty[1] && !grant_a;
        pop     = {grant_b, grant_a};
        push    = valid & ready & {2{!bus.flush_pipeline}};
    end

    for (genvar i = 0; i < 2; i++) begin : g_fifo
        logic [W-1:0]          mem [DEPTH];
        logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
        logic [DEPTH_LOG2:0]   cnt;

        always_ff @(posedge clk)
            if (push[i]) mem[wr_ptr] <= din[i];

        always_ff @(posedge clk or negedge reset_b)
            if (!reset_b) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                cnt    <= '0;
            end else if (bus.flush_pipeline) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                cnt    <= '0;
            end else begin
                wr_ptr <= wr_ptr + DEPTH_LOG2'(push[i]);
                rd_ptr <= rd_ptr + DEPTH_LOG2'(pop[i]);
                cnt    <= cnt + (DEPTH_LOG2+1)'(push[i]) - (DEPTH_LOG2+1)'(pop[i]);
            end

        assign count[i]    = cnt;
        assign head[i]     = mem[rd_ptr];
        assign nonempty[i] = cnt != '0;
        assign ready[i]    = cnt != (DEPTH_LOG2+1)'(DEPTH);
    end

    always_ff @(posedge clk or negedge reset_b)
        if (!reset_b) begin
            wec    <= 1'b0;
            addrc  <= '0;
            datac  <= '0;
            last_b <= 1'b1;
        end else if (bus.flush_pipeline) begin
            wec    <= 1'b0;
            last_b <= 1'b1;
        end else begin
            wec <= |pop;
            if (|pop) begin
                {addrc, datac} <= grant_a ? head[0] : head[1];
                last_b         <= grant_b;
            end
        end

    assign bus.wec        = wec;
    assign bus.addrc      = addrc;
    assign bus.datac      = datac;
    assign bus.a_ready    = ready[0];
    assign bus.b_ready    = ready[1];
    assign bus.wb_pending = (count[0] != '0) | (count[1] != '0) | wec;
endmodule

// File: tb/tb_regf_wb_arb.sv
// tb_regf_wb_arb: directed scenario checks of the write-back arbiter
module tb_regf_wb_arb;
    logic clk = 1'b0;
    logic reset_b = 1'b0;
    int checks = 0;
    int errors = 0;

    regf_wb_arb_if #(.AWIDTH(5), .DWIDTH(32)) bus ();

    regf_wb_arb #(.AWIDTH(5), .DWIDTH(32), .DEPTH_LOG2(2)) dut (
        .clk(clk),
        .reset_b(reset_b),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.halt = 0; bus.flush_pipeline = 0;
        bus.a_valid = 0; bus.a_addr = '0; bus.a_data = '0;
        bus.b_valid = 0; bus.b_addr = '0; bus.b_data = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_b = 0;
        tick();
        reset_b = 1;
    endtask

    task automatic push_a(input logic v, input logic [4:0] a);
        bus.a_valid = v; bus.a_addr = a; bus.a_data = 32'hA000 + 32'(a);
    endtask

    task automatic push_b(input logic v, input logic [4:0] a);
        bus.b_valid = v; bus.b_addr = a; bus.b_data = 32'hB000 + 32'(a);
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_b = 0;
        #3;
        checks++; if (bus.wec !== 1'b0) begin errors++; $display("FAIL reset_wec got %b exp 0", bus.wec); end
        checks++; if (bus.addrc !== 5'd0) begin errors++; $display("FAIL reset_addrc got %h exp 0", bus.addrc); end
        checks++; if (bus.datac !== 32'd0) begin errors++; $display("FAIL reset_datac got %h exp 0", bus.datac); end
        checks++; if (bus.a_ready !== 1'b1) begin errors++; $display("FAIL reset_a_ready got %b exp 1", bus.a_ready); end
        checks++; if (bus.b_ready !== 1'b1) begin errors++; $display("FAIL reset_b_ready got %b exp 1", bus.b_ready); end
        checks++; if (bus.wb_pending !== 1'b0) begin errors++; $display("FAIL reset_wb_pending got %b exp 0", bus.wb_pending); end
        tick();
        reset_b = 1;
    endtask

    task automatic test_single();
        do_reset();
        bus.a_valid = 1; bus.a_addr = 5'd3; bus.a_data = 32'h1234;
        tick();
        push_a(0, 0);
        checks++; if (bus.wec !== 1'b0) begin errors++; $display("FAIL single_wec_e1 got %b exp 0", bus.wec); end
        checks++; if (bus.wb_pending !== 1'b1) begin errors++; $display("FAIL single_pending_e1 got %b exp 1", bus.wb_pending); end
        tick();
        checks++; if (bus.wec !== 1'b1) begin errors++; $display("FAIL single_wec_e2 got %b exp 1", bus.wec); end
        checks++; if (bus.addrc !== 5'd3) begin errors++; $display("FAIL single_addrc got %h exp 3", bus.addrc); end
        checks++; if (bus.datac !== 32'h1234) begin errors++; $display("FAIL single_datac got %h exp 1234", bus.datac); end
        tick();
        checks++; if (bus.wec !== 1'b0) begin errors++; $display("FAIL single_wec_e3 got %b exp 0", bus.wec); end
        checks++; if (bus.wb_pending !== 1'b0) begin errors++; $display("FAIL single_pending_e3 got %b exp 0", bus.wb_pending); end
        checks++; if (bus.addrc !== 5'd3) begin errors++; $display("FAIL single_hold_addrc got %h exp 3", bus.addrc); end
    endtask

    task automatic test_round_robin();
        logic [4:0] exp [8] = '{5'd1, 5'd9, 5'd2, 5'd10, 5'd3, 5'd11, 5'd4, 5'd12};
        logic [31:0] exp_data;
        do_reset();
        push_a(1, 5'd1); push_b(1, 5'd9);
        tick();
        for (int k = 0; k < 8; k++) begin
            if (k < 3) begin push_a(1, 5'(k + 2)); push_b(1, 5'(k + 10)); end
            else begin push_a(0, 0); push_b(0, 0); end
            tick();
            exp_data = (exp[k] < 5'd9 ? 32'hA000 : 32'hB000) + 32'(exp[k]);
            checks++; if (bus.wec !== 1'b1) begin errors++; $display("FAIL rr_wec[%0d] got %b exp 1", k, bus.wec); end
            checks++; if (bus.addrc !== exp[k]) begin errors++; $display("FAIL rr_addrc[%0d] got %0d exp %0d", k, bus.addrc, exp[k]); end
            checks++; if (bus.datac !== exp_data) begin errors++; $display("FAIL rr_datac[%0d] got %h exp %h", k, bus.datac, exp_data); end
        end
        tick();
        checks++; if (bus.wec !== 1'b0) begin errors++; $display("FAIL rr_wec_end got %b exp 0", bus.wec); end
    endtask

    task automatic test_full();
        do_reset();
        bus.halt = 1;
        for (int k = 0; k < 4; k++) begin
            push_a(1, 5'(16 + k));
            tick();
        end
        checks++; if (bus.a_ready !== 1'b0) begin errors++; $display("FAIL full_a_ready got %b exp 0", bus.a_ready); end
        checks++; if (bus.wec !== 1'b0) begin errors++; $display("FAIL full_halt_wec got %b exp 0", bus.wec); end
        push_a(1, 5'd31);
        tick();
        push_a(0, 0);
        bus.halt = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (k == 0) begin
                checks++; if (bus.a_ready !== 1'b1) begin errors++; $display("FAIL full_ready_after_pop got %b exp 1", bus.a_ready); end
            end
            checks++; if (bus.wec !== 1'b1) begin errors++; $display("FAIL full_wec[%0d] got %b exp 1", k, bus.wec); end
            checks++; if (bus.addrc !== 5'(16 + k)) begin errors++; $display("FAIL full_addrc[%0d] got %0d exp %0d", k, bus.addrc, 16 + k); end
        end
        tick();
        checks++; if (bus.wec !== 1'b0) begin errors++; $display("FAIL full_no_fifth got %b exp 0", bus.wec); end
        checks++; if (bus.wb_pending !== 1'b0) begin errors++; $display("FAIL full_pending got %b exp 0", bus.wb_pending); end
    endtask

    task automatic test_halt();
        do_reset();
        push_b(1, 5'd5);
        tick();
        push_b(1, 5'd6);
        tick();
        checks++; if (bus.wec !== 1'b1 || bus.addrc !== 5'd5) begin errors++; $display("FAIL halt_first got wec=%b addrc=%0d exp wec=1 addrc=5", bus.wec, bus.addrc); end
        push_b(1, 5'd7);
        bus.halt = 1;
        for (int k = 0; k < 2; k++) begin
            tick();
            push_b(0, 0);
            checks++; if (bus.wec !== 1'b0) begin errors++; $display("FAIL halt_wec[%0d] got %b exp 0", k, bus.wec); end
            checks++; if (bus.addrc !== 5'd5) begin errors++; $display("FAIL halt_hold[%0d] got %0d exp 5", k, bus.addrc); end
        end
        bus.halt = 0;
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++; if (bus.wec !== 1'b1 || bus.addrc !== 5'(6 + k)) begin errors++; $display("FAIL halt_resume[%0d] got wec=%b addrc=%0d exp wec=1 addrc=%0d", k, bus.wec, bus.addrc, 6 + k); end
        end
        tick();
        checks++; if (bus.wec !== 1'b0 || bus.wb_pending !== 1'b0) begin errors++; $display("FAIL halt_end got wec=%b pending=%b exp 0 0", bus.wec, bus.wb_pending); end
    endtask

    task automatic test_flush();
        do_reset();
        push_a(1, 5'd30);
        tick();
        push_a(0, 0);
        tick();
        checks++; if (bus.wec !== 1'b1 || bus.addrc !== 5'd30) begin errors++; $display("FAIL flush_pre got wec=%b addrc=%0d exp wec=1 addrc=30", bus.wec, bus.addrc); end
        bus.halt = 1;
        push_a(1, 5'd1); push_b(1, 5'd9);
        tick();
        push_a(1, 5'd2); push_b(1, 5'd10);
        tick();
        push_a(0, 0); push_b(1, 5'd11);
        tick();
        bus.halt = 0;
        bus.flush_pipeline = 1;
        push_a(1, 5'd20); push_b(1, 5'd21);
        tick();
        bus.flush_pipeline = 0;
        push_a(0, 0); push_b(0, 0);
        checks++; if (bus.wec !== 1'b0) begin errors++; $display("FAIL flush_wec got %b exp 0", bus.wec); end
        checks++; if (bus.wb_pending !== 1'b0) begin errors++; $display("FAIL flush_pending got %b exp 0", bus.wb_pending); end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (bus.wec !== 1'b0) begin errors++; $display("FAIL flush_after[%0d] got %b exp 0", k, bus.wec); end
        end
        push_a(1, 5'd4); push_b(1, 5'd13);
        tick();
        push_a(0, 0); push_b(0, 0);
        tick();
        checks++; if (bus.wec !== 1'b1 || bus.addrc !== 5'd4) begin errors++; $display("FAIL flush_tie_a got wec=%b addrc=%0d exp wec=1 addrc=4", bus.wec, bus.addrc); end
        tick();
        checks++; if (bus.wec !== 1'b1 || bus.addrc !== 5'd13) begin errors++; $display("FAIL flush_tie_b got wec=%b addrc=%0d exp wec=1 addrc=13", bus.wec, bus.addrc); end
    endtask

    task automatic test_async_reset();
        do_reset();
        push_a(1, 5'd1); push_b(1, 5'd9);
        tick();
        push_a(1, 5'd2); push_b(0, 0);
        tick();
        push_a(0, 0);
        checks++; if (bus.wec !== 1'b1 || bus.addrc !== 5'd1) begin errors++; $display("FAIL areset_pre got wec=%b addrc=%0d exp wec=1 addrc=1", bus.wec, bus.addrc); end
        #1 reset_b = 0;
        #1;
        checks++; if (bus.wec !== 1'b0) begin errors++; $display("FAIL areset_wec got %b exp 0", bus.wec); end
        checks++; if (bus.addrc !== 5'd0 || bus.datac !== 32'd0) begin errors++; $display("FAIL areset_bus got addrc=%h datac=%h exp 0 0", bus.addrc, bus.datac); end
        checks++; if (bus.wb_pending !== 1'b0) begin errors++; $display("FAIL areset_pending got %b exp 0", bus.wb_pending); end
        checks++; if (bus.a_ready !== 1'b1 || bus.b_ready !== 1'b1) begin errors++; $display("FAIL areset_ready got %b%b exp 11", bus.a_ready, bus.b_ready); end
        tick();
        reset_b = 1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (bus.wec !== 1'b0) begin errors++; $display("FAIL areset_after[%0d] got %b exp 0", k, bus.wec); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_full();
        test_halt();
        test_flush();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/regf_wb_arb.md
# regf_wb_arb

Write-back arbiter and queue feeding register file port C. Collects results from two producer channels (A: ALU, B: memory/external), buffers each in a small FIFO, and selects one result per cycle round-robin. The selected result drives the registered write port `wec`/`addrc`/`datac`, which also clears the matching scoreboard bit in the register-status block. Flush and halt semantics match the scoreboard, so queued writes and scoreboard state stay consistent.

## Interface
- AWIDTH, 5, register address width
- DWIDTH, 32, register data width
- DEPTH_LOG2, 2, log2 of per-channel FIFO depth (depth = 1<<DEPTH_LOG2)

- clk  in  1  system clock
- reset_b  in  1  reset, asynchronous, active-low
- halt  in  1  system halt; no write-back issued while high
- flush_pipeline  in  1  discard all queued results
- a_valid  in  1  channel A result valid
- a_ready  out  1  channel A can accept (FIFO not full)
- a_addr  in  AWIDTH  channel A destination register
- a_data  in  DWIDTH  channel A result
- b_valid, b_ready, b_addr, b_data: same as A, for channel B
- wec  out  1  port C write enable (registered)
- addrc  out  AWIDTH  port C write address (registered)
- datac  out  DWIDTH  port C write data (registered)
- wb_pending  out  1  any FIFO non-empty or wec high

## Operation
- **Per-channel FIFO**
  - Storage: addr+data, depth 1<<DEPTH_LOG2.
  - Read/write pointers are DEPTH_LOG2 bits and wrap modulo depth.
  - Occupancy counter is DEPTH_LOG2+1 bits.
- **Accept and ready**
  - A push occurs on the edge where x_valid && x_ready && !flush_pipeline.
  - x_ready = !full. It depends on the registered count only and does not look ahead to a same-cycle pop.
- **Arbitration** (evaluated each edge when !flush_pipeline && !halt)
  - Neither FIFO non-empty: wec<=0.
  - Exactly one FIFO non-empty: grant it.
  - Both non-empty: grant the channel not granted last; `last_grant` resets to B, so A wins the first tie.
- **Grant**
  - Pops the head of the granted FIFO.
  - wec<=1; addrc/datac<=head entry; last_grant<=granted channel.
- **Halt**
  - Takes effect when halt=1 and flush_pipeline=0.
  - wec<=0; no pops; last_grant held.
  - Pushes are still accepted.
  - Rationale: the scoreboard ignores writebacks during halt, so none may be issued.
- **Flush** (flush_pipeline=1, priority over halt)
  - Both FIFOs emptied: pointers and counts go to 0.
  - Same-cycle pushes are discarded.
  - wec<=0; last_grant<=B.
- **Ordering**
  - Within a channel: strict FIFO order.
  - Across channels: arbitration order only. WAW avoidance between channels is the issue stage's responsibility; the block does no address compare.
- **Hold behaviour:** addrc/datac hold their last value while wec=0.
- **Simultaneous push and pop** on the same FIFO: count unchanged, both pointers advance.
- **Pop on an empty FIFO:** impossible by construction.
- **wb_pending** = (countA!=0) | (countB!=0) | wec, combinational from registers.

## Timing
- **Reset values:** wec=0, addrc=0, datac=0, a_ready=1, b_ready=1, wb_pending=0, FIFOs empty, last_grant=B.
- **Reset mid-operation:** all state returns to reset values asynchronously; queued entries are lost.
- **Latency:** a result accepted at edge k appears with wec=1 after edge k+1, at the earliest.
- **Throughput:**
  - One write-back per cycle total.
  - With both channels saturated, each channel gets one write every 2 cycles.
- **wec duration:** high for exactly one cycle per granted entry; back-to-back grants give continuous wec.
- **Ready after full:** x_ready rises the cycle after the pop that leaves the FIFO non-full.

## Test plan
- **Reset, then single write:** A pushes addr=3, data=0x1234 at edge 1 -> after edge 2, wec=1, addrc=3, datac=0x1234 for one cycle; wb_pending returns to 0 after edge 3.
- **Tie, round-robin:** A and B each push 4 entries (A addrs 1-4, B addrs 9-12) in the same cycles -> addrc sequence 1,9,2,10,3,11,4,12 with wec continuously high for 8 cycles.
- **Full/backpressure, DEPTH_LOG2=2:**
  - Hold halt=1 and push 4 entries on A -> a_ready=0 after the 4th push; a 5th a_valid is not accepted.
  - Release halt -> 4 writes in order; a_ready=1 the cycle after the first pop.
- **Halt mid-stream:**
  - 3 queued on B; assert halt for 2 cycles after the first write -> wec=0 during halt, with no entry lost or duplicated.
  - Remaining 2 writes follow in order after halt drops.
- **Flush:**
  - 2 queued on A, 3 on B, plus a push in the flush cycle -> wec=0 and wb_pending=0 after the flush edge; no later writes.
  - A subsequent tie grants A first.
- **Async reset mid-operation:** assert reset_b=0 while wec=1 with entries queued -> outputs go to reset values immediately; no writes occur after release.
